// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants, FSM encoding and baud divider helper for uart_tx_cfg
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_START  = 3'd1;
    localparam logic [STATE_W-1:0] S_DATA   = 3'd2;
    localparam logic [STATE_W-1:0] S_PARITY = 3'd3;
    localparam logic [STATE_W-1:0] S_STOP   = 3'd4;

    function automatic int baud_div(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Synchronous FIFO, show-ahead read, pointers carry an extra wrap bit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign empty    = (r_wr_ptr == r_rd_ptr);
    assign full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_en  = pop && !empty;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_wr_en  = push && (!full || w_rd_en);
    assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Configurable UART transmitter; optional input FIFO via UART_TX_FIFO_EN
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FRE    = 50,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_data_req,
    output logic                 tx_data_ready,
    output logic                 tx_busy,
    output logic                 tx_pin
);

    localparam int BAUD_DIV_CNT = baud_div(CLK_FRE, BAUD_RATE);
    localparam int CNT_W        = $clog2(BAUD_DIV_CNT);

    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(BAUD_DIV_CNT - 1);
    localparam logic [3:0]       c_data_last = 4'(DATA_BITS - 1);
    localparam logic [3:0]       c_stop_last = 4'(STOP_BITS - 1);

    if (BAUD_DIV_CNT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("uart_tx_cfg: illegal parameter combination");
    end

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_next;
    logic [CNT_W-1:0]     r_baud_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic                 w_bit_done;
    logic                 w_pin_next;
    logic                 w_start;
    logic [DATA_BITS-1:0] w_src_data;

`ifdef UART_TX_FIFO_EN
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_fifo_check
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
    end

    logic w_fifo_full;
    logic w_fifo_empty;

    assign tx_data_ready = !w_fifo_full;
    assign w_start       = (r_state == S_IDLE) && !w_fifo_empty;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_data_req && tx_data_ready),
        .push_data (tx_data),
        .pop       (w_start),
        .pop_data  (w_src_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );
`else
    assign tx_data_ready = (r_state == S_IDLE);
    assign w_start       = tx_data_req && tx_data_ready;
    assign w_src_data    = tx_data;
`endif

    assign w_bit_done = (r_baud_cnt == c_cnt_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            tx_busy <= 1'b0;
            tx_pin  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            tx_busy <= (w_state_next != S_IDLE);
            tx_pin  <= w_pin_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_next = S_START;
            S_START:  if (w_bit_done) w_state_next = S_DATA;
            S_DATA:   if (w_bit_done && r_bit_cnt == c_data_last)
                          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_done) w_state_next = S_STOP;
            S_STOP:   if (w_bit_done && r_bit_cnt == c_stop_last) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // The pin is one cycle behind the state, so the line falls the edge after accept.
    always_comb begin
        w_pin_next = 1'b1;
        case (r_state)
            S_START:  w_pin_next = 1'b0;
            S_DATA:   w_pin_next = r_shift[0];
            S_PARITY: w_pin_next = r_parity;
            default:  w_pin_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            if (w_start) begin
                r_shift  <= w_src_data;
                r_parity <= (PARITY == int'(PAR_ODD)) ? ~(^w_src_data) : ^w_src_data;
            end
        end else begin
            r_baud_cnt <= w_bit_done ? '0 : r_baud_cnt + 1'b1;
            if (w_bit_done) begin
                r_bit_cnt <= (w_state_next != r_state) ? 4'd0 : r_bit_cnt + 4'd1;
                if (r_state == S_DATA) r_shift <= r_shift >> 1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Self-checking bench for uart_tx_cfg (8N1, 8E1, 8O1, 7N2; FIFO build)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_cfg;

    localparam int CLKF = 50;
    localparam int BAUD = 5000000;
    localparam int BD   = 10;
`ifdef UART_TX_FIFO_EN
    localparam int FD = 4;
`else
    localparam int FD = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    logic [3:0] req = '0;
    wire  [3:0] pin_v, busy_v, rdy_v;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_cfg #(.CLK_FRE(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(FD)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_data_req(req[0]),
        .tx_data_ready(rdy_v[0]), .tx_busy(busy_v[0]), .tx_pin(pin_v[0]));
    uart_tx_cfg #(.CLK_FRE(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(FD)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_data_req(req[1]),
        .tx_data_ready(rdy_v[1]), .tx_busy(busy_v[1]), .tx_pin(pin_v[1]));
    uart_tx_cfg #(.CLK_FRE(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(FD)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_data_req(req[2]),
        .tx_data_ready(rdy_v[2]), .tx_busy(busy_v[2]), .tx_pin(pin_v[2]));
    uart_tx_cfg #(.CLK_FRE(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(FD)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_data_req(req[3]),
        .tx_data_ready(rdy_v[3]), .tx_busy(busy_v[3]), .tx_pin(pin_v[3]));

    function automatic int nbits(input int id);
        return (id == 3) ? 7 : 8;
    endfunction
    function automatic int par(input int id);
        return (id == 1) ? 2 : (id == 2) ? 1 : 0;
    endfunction
    function automatic int nstop(input int id);
        return (id == 3) ? 2 : 1;
    endfunction
    function automatic int frame_len(input int id);
        return (1 + nbits(id) + ((par(id) != 0) ? 1 : 0) + nstop(id)) * BD;
    endfunction

    // Line level of bit slot 'slot' of a frame carrying v: start, data LSB first, parity, stops.
    function automatic logic exp_bit(input int id, input logic [8:0] v, input int slot);
        int nb;
        int ones;
        nb = nbits(id);
        if (slot == 0) return 1'b0;
        if (slot <= nb) return v[slot-1];
        if (par(id) != 0 && slot == nb + 1) begin
            ones = $countones(v & 9'((1 << nb) - 1));
            return (par(id) == 2) ? logic'(ones % 2) : logic'(1 - ones % 2);
        end
        return 1'b1;
    endfunction

    task automatic set_data(input int id, input logic [8:0] v);
        case (id)
            0: d0 = v[7:0];
            1: d1 = v[7:0];
            2: d2 = v[7:0];
            default: d3 = v[6:0];
        endcase
    endtask

    // Entered at a negedge with req[id] high and data v presented.
    task automatic run_frame(input int id, input logic [8:0] v, input bit hold_req,
                             input bit chain, input logic [8:0] nv, input string tag);
        int fl;
        fl = frame_len(id);
        n_cmp++;
        if (rdy_v[id] !== 1'b1) begin
            n_bad++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, rdy_v[id]);
        end
        @(posedge clk);
        for (int j = 0; j <= fl; j++) begin
            @(negedge clk);
            if (j == 0 && !hold_req) req[id] = 1'b0;
            if (hold_req && j == fl - 1) req[id] = 1'b0;
            else if (j < fl - 1) set_data(id, 9'($urandom));
            n_cmp++;
            if (pin_v[id] !== ((j == 0) ? 1'b1 : exp_bit(id, v, (j - 1) / BD))) begin
                n_bad++;
                $display("FAIL %s pin@%0d: got %b want %b", tag, j, pin_v[id],
                         (j == 0) ? 1'b1 : exp_bit(id, v, (j - 1) / BD));
            end
            n_cmp++;
            if (busy_v[id] !== (j < fl)) begin
                n_bad++;
                $display("FAIL %s busy@%0d: got %b want %b", tag, j, busy_v[id], (j < fl));
            end
            n_cmp++;
            if (rdy_v[id] !== (j >= fl)) begin
                n_bad++;
                $display("FAIL %s ready@%0d: got %b want %b", tag, j, rdy_v[id], (j >= fl));
            end
            if (j == fl && chain) begin
                set_data(id, nv);
                req[id] = 1'b1;
            end
        end
        if (!chain) begin
            @(negedge clk);
            n_cmp++;
            if (pin_v[id] !== 1'b1 || busy_v[id] !== 1'b0) begin
                n_bad++;
                $display("FAIL %s idle_after: got pin=%b busy=%b want pin=1 busy=0",
                         tag, pin_v[id], busy_v[id]);
            end
        end
    endtask

    task automatic start(input int id, input logic [8:0] v);
        set_data(id, v);
        req[id] = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (pin_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || rdy_v[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_u%0d: got pin=%b busy=%b ready=%b want 1/0/1",
                         i, pin_v[i], busy_v[i], rdy_v[i]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (pin_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || rdy_v[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL post_reset_u%0d: got pin=%b busy=%b ready=%b want 1/0/1",
                         i, pin_v[i], busy_v[i], rdy_v[i]);
            end
        end
    endtask

    task automatic test_8n1();
        start(0, 9'h055);
        run_frame(0, 9'h055, 1'b0, 1'b0, 9'h0, "8n1_55");
    endtask

    task automatic test_parity();
        start(1, 9'h007);
        run_frame(1, 9'h007, 1'b0, 1'b0, 9'h0, "8e1_07");
        start(2, 9'h007);
        run_frame(2, 9'h007, 1'b0, 1'b0, 9'h0, "8o1_07");
    endtask

    task automatic test_back_to_back();
        logic [8:0] v2;
        v2 = 9'($urandom);
        start(3, 9'h041);
        run_frame(3, 9'h041, 1'b0, 1'b1, v2, "7n2_41");
        run_frame(3, v2, 1'b0, 1'b0, 9'h0, "7n2_next");
    endtask

    task automatic test_hold_req();
        logic [8:0] v;
        v = 9'($urandom);
        start(0, v);
        run_frame(0, v, 1'b1, 1'b0, 9'h0, "hold_req");
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if (pin_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL no_extra_frame@%0d: got pin=%b busy=%b want 1/0",
                         k, pin_v[0], busy_v[0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [8:0] v;
        v = 9'($urandom) & ~9'h004;
        start(0, v);
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (40) @(negedge clk);
        n_cmp++;
        if (pin_v[0] !== exp_bit(0, v, 3)) begin
            n_bad++;
            $display("FAIL pre_reset_pin: got %b want %b", pin_v[0], exp_bit(0, v, 3));
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (pin_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: got pin=%b busy=%b ready=%b want 1/0/1",
                     pin_v[0], busy_v[0], rdy_v[0]);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = 9'($urandom);
        start(0, v);
        run_frame(0, v, 1'b0, 1'b0, 9'h0, "after_reset");
    endtask

    task automatic test_random();
        int id;
        logic [8:0] v;
        logic [8:0] v2;
        for (int i = 0; i < 8; i++) begin
            id = int'($urandom_range(0, 3));
            v  = 9'($urandom);
            v2 = 9'($urandom);
            start(id, v);
            if (i % 3 == 2) begin
                run_frame(id, v, 1'b0, 1'b1, v2, "rand_chain");
                run_frame(id, v2, 1'b0, 1'b0, 9'h0, "rand_chain2");
            end else begin
                run_frame(id, v, 1'b0, 1'b0, 9'h0, "rand");
            end
        end
    endtask

    task automatic test_fifo();
        logic [8:0] vals [5];
        int push_cyc;
        int fall_cyc;
        int fl;
        bit seen;
        fl = frame_len(0);
        vals[0] = 9'h0A1; vals[1] = 9'h0B2; vals[2] = 9'h0C3;
        vals[3] = 9'h0D4; vals[4] = 9'h0E5;
        push_cyc = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    n_cmp++;
                    if (rdy_v[0] !== 1'b1) begin
                        n_bad++;
                        $display("FAIL fifo_ready_push%0d: got %b want 1", i, rdy_v[0]);
                    end
                    start(0, vals[i]);
                    @(posedge clk);
                    @(negedge clk);
                    if (i == 0) push_cyc = cyc;
                end
                req[0] = 1'b0;
                n_cmp++;
                if (rdy_v[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL fifo_full_ready: got %b want 0", rdy_v[0]);
                end
            end
            begin
                seen = 1'b0;
                fall_cyc = 0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    if (pin_v[0] === 1'b0) begin
                        seen = 1'b1;
                        fall_cyc = cyc;
                    end
                end
                n_cmp++;
                if (!seen || fall_cyc != push_cyc + 2) begin
                    n_bad++;
                    $display("FAIL fifo_first_fall: got seen=%b cyc=%0d want cyc=%0d",
                             seen, fall_cyc, push_cyc + 2);
                end
                if (seen) begin
                    for (int k = 1; k < 5 * (fl + 1); k++) begin
                        @(negedge clk);
                        n_cmp++;
                        if (pin_v[0] !== (((k % (fl + 1)) == fl) ? 1'b1 :
                                exp_bit(0, vals[k / (fl + 1)], (k % (fl + 1)) / BD))) begin
                            n_bad++;
                            $display("FAIL fifo_stream@%0d: got %b", k, pin_v[0]);
                        end
                    end
                end
            end
        join
        n_cmp++;
        if (busy_v[0] !== 1'b0 || rdy_v[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL fifo_drained: got busy=%b ready=%b want 0/1", busy_v[0], rdy_v[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
`ifdef UART_TX_FIFO_EN
        test_fifo();
`else
        test_8n1();
        test_parity();
        test_back_to_back();
        test_hold_req();
        test_reset_mid_frame();
        test_random();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
